stereo_limiter: RTL and testbench

Per-sample stereo peak limiter between `pan` and `dac_transmitter`. It takes the fixed-point left/right pair once per sample period, tracks a smoothed gain (fast attack, slow release), and produces saturated `WIDTH`-bit integer samples for the DAC serializer. The datapath is a small FSM with one shared multiplier that runs in the `sys_clk` domain, using a one-cycle `in_valid` strobe once per sample.

---
 rtl/stereo_limiter_if.sv | 29 ++
 rtl/stereo_limiter.sv | 172 +++++++++++++++++
 tb/tb_stereo_limiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/stereo_limiter_if.sv
// Sample-rate bus between the pan stage, the stereo limiter and the DAC serializer.
// Carries the input pair, limiter controls, limited output pair and status.
// Master drives samples and controls; slave returns limited samples and status.
interface stereo_limiter_if #(
    parameter int WIDTH    = 24,
    parameter int IN_WIDTH = 32
);
    logic                       enable;
    logic                       in_valid;
    logic signed [IN_WIDTH-1:0] left_in;
    logic signed [IN_WIDTH-1:0] right_in;
    logic        [WIDTH-1:0]    threshold;
    logic signed [WIDTH-1:0]    left_out;
    logic signed [WIDTH-1:0]    right_out;
    logic                       out_valid;
    logic                       busy;
    logic                       overrun;
    logic        [15:0]         gain;

    modport master (
        output enable, in_valid, left_in, right_in, threshold,
        input  left_out, right_out, out_valid, busy, overrun, gain
    );

    modport slave (
        input  enable, in_valid, left_in, right_in, threshold,
        output left_out, right_out, out_valid, busy, overrun, gain
    );
endinterface

// File: rtl/stereo_limiter.sv
// Stereo peak limiter: smoothed Q1.15 gain (fast attack, slow release), saturated WIDTH-bit output pair.
// Latency: 5 cycles from accepted in_valid to out_valid; one shared multiplier.
// No backpressure: in_valid while busy is dropped and flagged on overrun the next cycle.
module stereo_limiter #(
    parameter int WIDTH        = 24,
    parameter int IN_WIDTH     = 32,
    parameter int FRAC         = 8,
    parameter int ATTACK_SHIFT = 3,
    parameter int RELEASE_STEP = 16,
    parameter int GAIN_MIN     = 1024
) (
    input  logic             sys_clk,
    input  logic             rst,
    stereo_limiter_if.slave  lim
);
    // Working width covers both the widened input and the WIDTH+17-bit product.
    localparam int P_W = (IN_WIDTH > WIDTH + 18) ? IN_WIDTH : WIDTH + 18;

    localparam logic [16:0] UNITY = 17'd32768;
    localparam logic [16:0] G_MIN = 17'(GAIN_MIN);
    localparam logic [16:0] G_REL = 17'(RELEASE_STEP);

    typedef enum logic [2:0] {
        IDLE,
        PEAK,
        GAIN,
        MUL_L,
        MUL_R,
        OUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [WIDTH-1:0] s_l;
    logic signed [WIDTH-1:0] s_r;
    logic        [WIDTH-1:0] thr_q;
    logic                    en_q;
    logic        [WIDTH-1:0] peak_q;
    logic        [15:0]      gain_q;
    logic signed [WIDTH-1:0] left_hold;
    logic signed [WIDTH-1:0] left_q;
    logic signed [WIDTH-1:0] right_q;
    logic                    out_valid_q;
    logic                    overrun_q;

    logic signed [WIDTH:0]   mul_a;
    logic signed [P_W-1:0]   product;
    logic signed [P_W-1:0]   prod_sh;
    logic                    over_thr;
    logic        [16:0]      g_cur;
    logic        [16:0]      g_att;
    logic        [16:0]      g_rel;
    logic        [15:0]      gain_nxt;

    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [P_W-1:0] v);
        logic signed [P_W-1:0] hi;
        logic signed [P_W-1:0] lo;
        hi = {{(P_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
        lo = {{(P_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
        if (v > hi)
            sat_w = hi[WIDTH-1:0];
        else if (v < lo)
            sat_w = lo[WIDTH-1:0];
        else
            sat_w = v[WIDTH-1:0];
    endfunction

    // Magnitude with the most negative code folded onto the most positive one.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        if (v == {1'b1, {(WIDTH-1){1'b0}}})
            mag = {1'b0, {(WIDTH-1){1'b1}}};
        else if (v[WIDTH-1])
            mag = -v;
        else
            mag = v;
    endfunction

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (lim.in_valid) state_nxt = PEAK;
            PEAK:    state_nxt = GAIN;
            GAIN:    state_nxt = MUL_L;
            MUL_L:   state_nxt = MUL_R;
            MUL_R:   state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One multiplier: peak*gain in GAIN, then each channel times the updated gain.
    always_comb begin
        mul_a = '0;
        case (state)
            GAIN:    mul_a = {1'b0, peak_q};
            MUL_L:   mul_a = {s_l[WIDTH-1], s_l};
            MUL_R:   mul_a = {s_r[WIDTH-1], s_r};
            default: mul_a = '0;
        endcase
    end

    assign product  = P_W'(mul_a) * $signed({{(P_W-16){1'b0}}, gain_q});
    assign prod_sh  = product >>> 15;
    assign over_thr = prod_sh > $signed({{(P_W-WIDTH){1'b0}}, thr_q});

    always_comb begin
        g_cur    = {1'b0, gain_q};
        g_att    = g_cur - (g_cur >> ATTACK_SHIFT);
        g_rel    = g_cur + G_REL;
        gain_nxt = gain_q;
        if (!en_q)
            gain_nxt = UNITY[15:0];
        else if (over_thr)
            gain_nxt = (g_att < G_MIN) ? G_MIN[15:0] : g_att[15:0];
        else if (g_cur < UNITY)
            gain_nxt = (g_rel > UNITY) ? UNITY[15:0] : g_rel[15:0];
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            s_l         <= '0;
            s_r         <= '0;
            thr_q       <= '0;
            en_q        <= 1'b0;
            peak_q      <= '0;
            gain_q      <= UNITY[15:0];
            left_hold   <= '0;
            left_q      <= '0;
            right_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            overrun_q   <= lim.in_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (lim.in_valid) begin
                        s_l   <= sat_w(P_W'(lim.left_in >>> FRAC));
                        s_r   <= sat_w(P_W'(lim.right_in >>> FRAC));
                        thr_q <= lim.threshold;
                        en_q  <= lim.enable;
                    end
                end
                PEAK: peak_q <= (mag(s_l) > mag(s_r)) ? mag(s_l) : mag(s_r);
                GAIN: gain_q <= gain_nxt;
                MUL_L: left_hold <= sat_w(prod_sh);
                // Both channels land together so they are valid for the whole OUT cycle.
                MUL_R: begin
                    left_q      <= left_hold;
                    right_q     <= sat_w(prod_sh);
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign lim.busy      = (state != IDLE);
    assign lim.gain      = gain_q;
    assign lim.left_out  = left_q;
    assign lim.right_out = right_q;
    assign lim.out_valid = out_valid_q;
    assign lim.overrun   = overrun_q;
endmodule

// File: tb/tb_stereo_limiter.sv
// Bench for stereo_limiter: directed and random samples against an arithmetic reference model.
// Each sample runs a fixed 7-cycle window; latency, outputs and gain are compared per sample.
// Inputs are driven on the falling edge and outputs sampled there, away from the active edge.
module tb_stereo_limiter;
    logic sys_clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   m_gain = 32768;

    stereo_limiter_if #(.WIDTH(24), .IN_WIDTH(32)) lim ();

    stereo_limiter #(
        .WIDTH(24), .IN_WIDTH(32), .FRAC(8),
        .ATTACK_SHIFT(3), .RELEASE_STEP(16), .GAIN_MIN(1024)
    ) dut (
        .sys_clk(sys_clk),
        .rst    (rst),
        .lim    (lim)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint clamp24(input longint v);
        if (v > 64'sd8388607) return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    // Reference: one sample through the limiter rules, updating the model gain.
    task automatic model(input int l, input int r, input int unsigned thr, input bit en,
                         output longint el, output longint er);
        longint sl, sr, al, ar, peak, pk;
        sl = clamp24(longint'(l) >>> 8);
        sr = clamp24(longint'(r) >>> 8);
        al = (sl < 0) ? -sl : sl;
        ar = (sr < 0) ? -sr : sr;
        if (al > 8388607) al = 8388607;
        if (ar > 8388607) ar = 8388607;
        peak = (al > ar) ? al : ar;
        pk = (peak * m_gain) >>> 15;
        if (!en) begin
            m_gain = 32768;
        end else if (pk > longint'(thr)) begin
            m_gain = m_gain - m_gain / 8;
            if (m_gain < 1024) m_gain = 1024;
        end else if (m_gain < 32768) begin
            m_gain = m_gain + 16;
            if (m_gain > 32768) m_gain = 32768;
        end
        el = clamp24((sl * m_gain) >>> 15);
        er = clamp24((sr * m_gain) >>> 15);
    endtask

    task automatic run_sample(input int l, input int r, input int unsigned thr, input bit en,
                              input string tag);
        longint el, er;
        int     lat, npulse;
        model(l, r, thr, en, el, er);
        @(negedge sys_clk);
        lim.left_in   = l;
        lim.right_in  = r;
        lim.threshold = thr[23:0];
        lim.enable    = en;
        lim.in_valid  = 1'b1;
        lat    = 0;
        npulse = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge sys_clk);
            lim.in_valid = 1'b0;
            if (k == 1) begin
                chk({tag, ".busy"}, lim.busy, 1);
                lim.left_in  = int'($urandom);
                lim.right_in = int'($urandom);
            end
            if (k == 2) begin
                lim.threshold = 24'($urandom);
                lim.enable    = 1'($urandom);
            end
            if (lim.out_valid === 1'b1) begin
                npulse++;
                lat = k;
            end
        end
        chk({tag, ".lat"}, lat, 5);
        chk({tag, ".npulse"}, npulse, 1);
        chk({tag, ".left"}, lim.left_out, el);
        chk({tag, ".right"}, lim.right_out, er);
        chk({tag, ".gain"}, lim.gain, m_gain);
        chk({tag, ".idle"}, lim.busy, 0);
    endtask

    initial begin
        longint el, er;
        int     n_ov, k_ov, n_or, k_or, npulse;

        rst           = 1'b1;
        lim.enable    = 1'b0;
        lim.in_valid  = 1'b0;
        lim.left_in   = '0;
        lim.right_in  = '0;
        lim.threshold = '0;
        #1;
        chk("rst.left", lim.left_out, 0);
        chk("rst.right", lim.right_out, 0);
        chk("rst.gain", lim.gain, 32768);
        chk("rst.busy", lim.busy, 0);
        chk("rst.out_valid", lim.out_valid, 0);
        chk("rst.overrun", lim.overrun, 0);
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;

        run_sample(1000 << 8, -2000 << 8, 32'h400000, 1'b1, "pass");
        chk("pass.left_lit", lim.left_out, 1000);
        chk("pass.right_lit", lim.right_out, -2000);
        chk("pass.gain_lit", lim.gain, 32768);

        run_sample(32'h20000000, 0, 32'h100000, 1'b1, "attack");
        chk("attack.gain_lit", lim.gain, 28672);
        chk("attack.left_lit", lim.left_out, 1835008);
        chk("attack.right_lit", lim.right_out, 0);

        for (int i = 0; i < 60 && m_gain != 1024; i++)
            run_sample(32'h20000000, 0, 0, 1'b1, "floor");
        chk("floor.reached", lim.gain, 1024);
        repeat (2) run_sample(32'h20000000, 0, 0, 1'b1, "floor_hold");
        chk("floor.held", lim.gain, 1024);

        run_sample(0, 0, 0, 1'b0, "bypass");
        run_sample(32'h20000000, 0, 32'h100000, 1'b1, "reattack");
        chk("reattack.gain_lit", lim.gain, 28672);
        for (int i = 0; i < 256; i++)
            run_sample(0, 0, 32'h100000, 1'b1, "release");
        chk("release.gain_lit", lim.gain, 32768);
        run_sample(0, 0, 32'h100000, 1'b1, "release_hold");
        chk("release.hold_lit", lim.gain, 32768);

        run_sample(32'h80000000, 32'h7FFFFFFF, 0, 1'b0, "edge");
        chk("edge.left_lit", lim.left_out, -8388608);
        chk("edge.right_lit", lim.right_out, 8388607);
        chk("edge.gain_lit", lim.gain, 32768);
        run_sample(32'h80000000, 0, 32'h7FFFFF, 1'b1, "edgepk");
        chk("edgepk.gain_lit", lim.gain, 32768);

        // Second strobe two cycles after the first must be dropped and flagged.
        model(100 << 8, 50 << 8, 32'h400000, 1'b1, el, er);
        @(negedge sys_clk);
        lim.left_in   = 100 << 8;
        lim.right_in  = 50 << 8;
        lim.threshold = 24'h400000;
        lim.enable    = 1'b1;
        lim.in_valid  = 1'b1;
        n_ov = 0; k_ov = 0; n_or = 0; k_or = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge sys_clk);
            lim.in_valid = (k == 2);
            if (k == 2) lim.left_in = 7777 << 8;
            if (lim.out_valid === 1'b1) begin n_ov++; k_ov = k; end
            if (lim.overrun === 1'b1) begin n_or++; k_or = k; end
        end
        chk("ovr.out_count", n_ov, 1);
        chk("ovr.out_cycle", k_ov, 5);
        chk("ovr.flag_count", n_or, 1);
        chk("ovr.flag_cycle", k_or, 3);
        chk("ovr.left", lim.left_out, el);
        chk("ovr.right", lim.right_out, er);

        run_sample(32'h20000000, 0, 32'h100000, 1'b1, "pre_rst");
        @(negedge sys_clk);
        lim.left_in   = 32'h20000000;
        lim.right_in  = 0;
        lim.threshold = 24'h100000;
        lim.enable    = 1'b1;
        lim.in_valid  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge sys_clk);
            lim.in_valid = 1'b0;
        end
        #1 rst = 1'b1;
        #1;
        chk("midrst.left", lim.left_out, 0);
        chk("midrst.right", lim.right_out, 0);
        chk("midrst.gain", lim.gain, 32768);
        chk("midrst.busy", lim.busy, 0);
        chk("midrst.out_valid", lim.out_valid, 0);
        m_gain = 32768;
        npulse = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            if (k == 3) rst = 1'b0;
            if (lim.out_valid === 1'b1) npulse++;
        end
        chk("midrst.no_out", npulse, 0);
        run_sample(300 << 8, -400 << 8, 32'h400000, 1'b1, "after_rst");
        chk("after_rst.left_lit", lim.left_out, 300);

        for (int i = 0; i < 40; i++) begin
            int l, r;
            int unsigned thr;
            bit en;
            l   = int'($urandom);
            r   = int'($urandom);
            if (i % 2 == 1) begin
                l = l >>> 6;
                r = r >>> 6;
            end
            thr = $urandom_range(32'hFFFFFF, 0);
            en  = ($urandom_range(7, 0) != 0);
            run_sample(l, r, thr, en, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
